// File: rtl/memwb_stage.sv
// Memory/writeback stage: data BRAM port, accelerator bus master, registered writeback.
// Optional bus watchdog enabled by defining MEMWB_BUS_TIMEOUT_EN.
module memwb_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_bustoreg,
    input  logic              ex_memwrite,
    input  logic              ex_buswrite,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_src2_data,
    input  logic [REG_AW-1:0] ex_regwraddr,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              bus_req_valid,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    input  logic              bus_req_ready,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_regwraddr,
    output logic [DATA_W-1:0] wb_regwrdata,
    output logic              stall_out,
    output logic              bus_timeout_err
);

    if (MEM_LAT < 1 || MEM_LAT > 3 || BUS_TIMEOUT < 1) begin : g_param_check
        $error("memwb_stage: MEM_LAT must be 1..3 and BUS_TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        BUS_REQ,
        BUS_RSP
    } state_t;

    state_t state, state_nxt;

    logic              accept;
    logic              is_load, is_store, is_bus_rd, is_bus_wr, is_alu;
    logic              lat_done, req_fire, rsp_fire, timeout_hit;
    logic [1:0]        lat_cnt;
    logic              pend_regwrite;
    logic [REG_AW-1:0] pend_regaddr;

    // Reset blocks acceptance so the BRAM port stays quiet while rst is high.
    assign accept    = !rst && (state == IDLE) && ex_valid;
    assign is_load   = accept && ex_memtoreg;
    assign is_store  = accept && !ex_memtoreg && ex_memwrite;
    assign is_bus_rd = accept && !ex_memtoreg && !ex_memwrite && ex_bustoreg;
    assign is_bus_wr = accept && !ex_memtoreg && !ex_memwrite && !ex_bustoreg && ex_buswrite;
    assign is_alu    = accept && !ex_memtoreg && !ex_memwrite && !ex_bustoreg && !ex_buswrite;

    assign lat_done  = (state == MEM_WAIT) && (lat_cnt == 2'(MEM_LAT));
    assign req_fire  = (state == BUS_REQ) && bus_req_ready;
    assign rsp_fire  = (state == BUS_RSP) && bus_rsp_valid;
    assign stall_out = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dmem_en    = is_load || is_store;
        dmem_we    = is_store;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (is_load || is_store) dmem_addr = ex_alu_out[ADDR_W-1:0];
        if (is_store)            dmem_wdata = ex_src2_data;
        case (state)
            IDLE: begin
                if (is_load)                     state_nxt = MEM_WAIT;
                else if (is_bus_rd || is_bus_wr) state_nxt = BUS_REQ;
            end
            MEM_WAIT: begin
                if (lat_done) state_nxt = IDLE;
            end
            BUS_REQ: begin
                if (req_fire)         state_nxt = bus_req_we ? IDLE : BUS_RSP;
                else if (timeout_hit) state_nxt = IDLE;
            end
            BUS_RSP: begin
                if (rsp_fire || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            wb_regwrite   <= 1'b0;
            wb_regwraddr  <= '0;
            wb_regwrdata  <= '0;
            lat_cnt       <= '0;
            pend_regwrite <= 1'b0;
            pend_regaddr  <= '0;
        end else begin
            bus_req_valid <= (state_nxt == BUS_REQ);
            wb_regwrite   <= 1'b0;

            if (is_load || is_bus_rd) begin
                pend_regwrite <= ex_regwrite;
                pend_regaddr  <= ex_regwraddr;
            end

            if (is_load)
                lat_cnt <= 2'd1;
            else if ((state == MEM_WAIT) && !lat_done)
                lat_cnt <= lat_cnt + 2'd1;

            if (is_bus_rd || is_bus_wr) begin
                bus_req_we    <= is_bus_wr;
                bus_req_addr  <= ex_alu_out[ADDR_W-1:0];
                bus_req_wdata <= ex_src2_data;
            end

            // Address/data only move on a real write so they hold between pulses.
            if (is_alu) begin
                wb_regwrite <= ex_regwrite;
                if (ex_regwrite) begin
                    wb_regwraddr <= ex_regwraddr;
                    wb_regwrdata <= ex_alu_out;
                end
            end

            if (lat_done) begin
                wb_regwrite <= pend_regwrite;
                if (pend_regwrite) begin
                    wb_regwraddr <= pend_regaddr;
                    wb_regwrdata <= dmem_rdata;
                end
            end

            if (rsp_fire) begin
                wb_regwrite <= pend_regwrite;
                if (pend_regwrite) begin
                    wb_regwraddr <= pend_regaddr;
                    wb_regwrdata <= bus_rsp_data;
                end
            end
        end
    end

`ifdef MEMWB_BUS_TIMEOUT_EN
    localparam int unsigned TO_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt;

    // Completion in the same cycle as expiry wins; the counter only aborts a stuck transfer.
    assign timeout_hit = (((state == BUS_REQ) && !bus_req_ready) ||
                          ((state == BUS_RSP) && !bus_rsp_valid)) &&
                         (to_cnt == TO_W'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt          <= '0;
            bus_timeout_err <= 1'b0;
        end else begin
            if (is_bus_rd || is_bus_wr)
                to_cnt <= '0;
            else if ((state == BUS_REQ) || (state == BUS_RSP))
                to_cnt <= to_cnt + TO_W'(1);
            if (timeout_hit)
                bus_timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign bus_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: vector table for single-cycle ops plus
// hand-written sequences for load latency, bus handshakes, reset abort and timeout.
module tb_memwb_stage;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned REG_AW      = 4;
    localparam int unsigned MEM_LAT     = 2;
    localparam int unsigned BUS_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, ex_regwrite, ex_memtoreg, ex_bustoreg, ex_memwrite, ex_buswrite;
    logic [DATA_W-1:0] ex_alu_out, ex_src2_data;
    logic [REG_AW-1:0] ex_regwraddr;
    logic              dmem_en, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
    logic              bus_req_valid, bus_req_we, bus_req_ready, bus_rsp_valid;
    logic [ADDR_W-1:0] bus_req_addr;
    logic [DATA_W-1:0] bus_req_wdata, bus_rsp_data;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_regwraddr;
    logic [DATA_W-1:0] wb_regwrdata;
    logic              stall_out, bus_timeout_err;

    always #5 clk = ~clk;

    memwb_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
        .MEM_LAT(MEM_LAT), .BUS_TIMEOUT(BUS_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_bustoreg(ex_bustoreg), .ex_memwrite(ex_memwrite), .ex_buswrite(ex_buswrite),
        .ex_alu_out(ex_alu_out), .ex_src2_data(ex_src2_data), .ex_regwraddr(ex_regwraddr),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_ready(bus_req_ready),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
        .wb_regwrite(wb_regwrite), .wb_regwraddr(wb_regwraddr), .wb_regwrdata(wb_regwrdata),
        .stall_out(stall_out), .bus_timeout_err(bus_timeout_err)
    );

    // BRAM model with MEM_LAT cycles of read latency.
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] rd_pipe [0:1];
    always @(posedge clk) begin
        if (dmem_en && dmem_we)  mem[dmem_addr[7:0]] <= dmem_wdata;
        if (dmem_en && !dmem_we) rd_pipe[0] <= mem[dmem_addr[7:0]];
        rd_pipe[1] <= rd_pipe[0];
    end
    assign dmem_rdata = rd_pipe[MEM_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_bustoreg = 0;
        ex_memwrite = 0; ex_buswrite = 0;
        ex_alu_out = '0; ex_src2_data = '0; ex_regwraddr = '0;
    endtask

    typedef struct {
        logic        valid, regwrite, memwrite, bustoreg, buswrite, rsp;
        logic [15:0] alu, src2;
        logic [3:0]  rwaddr;
        logic        e_en, e_we;
        logic [15:0] e_addr, e_wdata;
        logic        e_wb;
        logic [3:0]  e_wbaddr;
        logic [15:0] e_wbdata;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // valid rw mw bt bw rsp  alu      src2     rd  | en we addr     wdata   | wb wbaddr wbdata
        vecs[0] = '{1,1,0,0,0,0, 16'h1234, 16'h3333, 4'd5,  0,0,16'h0000,16'h0000, 1,4'd5, 16'h1234};
        vecs[1] = '{1,0,0,0,0,0, 16'hFFFF, 16'h0000, 4'd9,  0,0,16'h0000,16'h0000, 0,4'd5, 16'h1234};
        vecs[2] = '{1,1,1,0,0,0, 16'h0042, 16'hC0DE, 4'd3,  1,1,16'h0042,16'hC0DE, 0,4'd5, 16'h1234};
        vecs[3] = '{1,0,1,1,1,0, 16'h0080, 16'h1111, 4'd6,  1,1,16'h0080,16'h1111, 0,4'd5, 16'h1234};
        vecs[4] = '{0,1,1,0,0,0, 16'h00C0, 16'h2222, 4'd6,  0,0,16'h0000,16'h0000, 0,4'd5, 16'h1234};
        vecs[5] = '{0,1,0,1,0,1, 16'h00D0, 16'h0000, 4'd6,  0,0,16'h0000,16'h0000, 0,4'd5, 16'h1234};
        vecs[6] = '{1,1,0,0,0,1, 16'hA5A5, 16'h0000, 4'd15, 0,0,16'h0000,16'h0000, 1,4'd15,16'hA5A5};
        vecs[7] = '{0,0,0,0,0,0, 16'h0000, 16'h0000, 4'd0,  0,0,16'h0000,16'h0000, 0,4'd15,16'hA5A5};

        rst = 1; idle_in();
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = '0;
        repeat (3) tick();
        chk("rst dmem_en", dmem_en, 0);
        chk("rst dmem_we", dmem_we, 0);
        chk("rst dmem_addr", dmem_addr, 0);
        chk("rst dmem_wdata", dmem_wdata, 0);
        chk("rst bus_req_valid", bus_req_valid, 0);
        chk("rst bus_req_we", bus_req_we, 0);
        chk("rst bus_req_addr", bus_req_addr, 0);
        chk("rst bus_req_wdata", bus_req_wdata, 0);
        chk("rst wb_regwrite", wb_regwrite, 0);
        chk("rst wb_regwraddr", wb_regwraddr, 0);
        chk("rst wb_regwrdata", wb_regwrdata, 0);
        chk("rst stall_out", stall_out, 0);
        chk("rst bus_timeout_err", bus_timeout_err, 0);
        rst = 0;

        // Single-cycle instructions: ALU ops, stores, priority, idle and stray responses.
        for (int i = 0; i < 8; i++) begin
            ex_valid = vecs[i].valid; ex_regwrite = vecs[i].regwrite;
            ex_memtoreg = 0; ex_memwrite = vecs[i].memwrite;
            ex_bustoreg = vecs[i].bustoreg; ex_buswrite = vecs[i].buswrite;
            ex_alu_out = vecs[i].alu; ex_src2_data = vecs[i].src2; ex_regwraddr = vecs[i].rwaddr;
            bus_rsp_valid = vecs[i].rsp; bus_rsp_data = 16'hDEAD;
            #1;
            chk($sformatf("vec%0d dmem_en", i), dmem_en, vecs[i].e_en);
            chk($sformatf("vec%0d dmem_we", i), dmem_we, vecs[i].e_we);
            if (vecs[i].e_en) begin
                chk($sformatf("vec%0d dmem_addr", i), dmem_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
            end
            tick();
            chk($sformatf("vec%0d wb_regwrite", i), wb_regwrite, vecs[i].e_wb);
            chk($sformatf("vec%0d wb_regwraddr", i), wb_regwraddr, vecs[i].e_wbaddr);
            chk($sformatf("vec%0d wb_regwrdata", i), wb_regwrdata, vecs[i].e_wbdata);
            chk($sformatf("vec%0d stall_out", i), stall_out, 0);
            chk($sformatf("vec%0d bus_req_valid", i), bus_req_valid, 0);
        end
        bus_rsp_valid = 0;
        idle_in();
        tick();

        // Store BEEF to 0x0040, then load it into r3 (load outranks the store flag).
        ex_valid = 1; ex_memwrite = 1; ex_alu_out = 16'h0040; ex_src2_data = 16'hBEEF;
        tick();
        chk("st stall_out", stall_out, 0);
        idle_in();
        ex_valid = 1; ex_memtoreg = 1; ex_memwrite = 1; ex_regwrite = 1;
        ex_alu_out = 16'h0040; ex_regwraddr = 4'd3;
        #1;
        chk("ld dmem_en", dmem_en, 1);
        chk("ld dmem_we", dmem_we, 0);
        chk("ld dmem_addr", dmem_addr, 16'h0040);
        tick();
        chk("ld T+1 stall_out", stall_out, 1);
        chk("ld T+1 wb_regwrite", wb_regwrite, 0);
        chk("ld T+1 dmem_en", dmem_en, 0);
        tick();
        chk("ld T+2 stall_out", stall_out, 1);
        chk("ld T+2 wb_regwrite", wb_regwrite, 0);
        tick();
        idle_in();
        chk("ld T+3 stall_out", stall_out, 0);
        chk("ld T+3 wb_regwrite", wb_regwrite, 1);
        chk("ld T+3 wb_regwraddr", wb_regwraddr, 3);
        chk("ld T+3 wb_regwrdata", wb_regwrdata, 16'hBEEF);
        tick();
        chk("ld T+4 wb_regwrite", wb_regwrite, 0);
        chk("ld T+4 wb_regwrdata", wb_regwrdata, 16'hBEEF);

        // Bus read to r7: ready low three cycles, response two cycles after handshake.
        ex_valid = 1; ex_bustoreg = 1; ex_regwrite = 1; ex_alu_out = 16'h0300; ex_regwraddr = 4'd7;
        tick();
        ex_alu_out = 16'hFFFF;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("brd T+%0d bus_req_valid", c), bus_req_valid, 1);
            chk($sformatf("brd T+%0d bus_req_addr", c), bus_req_addr, 16'h0300);
            chk($sformatf("brd T+%0d bus_req_we", c), bus_req_we, 0);
            chk($sformatf("brd T+%0d stall_out", c), stall_out, 1);
            tick();
        end
        bus_req_ready = 1; bus_rsp_valid = 1; bus_rsp_data = 16'hDEAD;
        chk("brd T+4 bus_req_valid", bus_req_valid, 1);
        chk("brd T+4 bus_req_addr", bus_req_addr, 16'h0300);
        tick();
        bus_req_ready = 0; bus_rsp_valid = 0;
        chk("brd T+5 bus_req_valid", bus_req_valid, 0);
        chk("brd T+5 stall_out", stall_out, 1);
        chk("brd T+5 wb_regwrite", wb_regwrite, 0);
        tick();
        bus_rsp_valid = 1; bus_rsp_data = 16'h00A5;
        chk("brd T+6 stall_out", stall_out, 1);
        chk("brd T+6 wb_regwrite", wb_regwrite, 0);
        tick();
        bus_rsp_valid = 0;
        idle_in();
        chk("brd T+7 wb_regwrite", wb_regwrite, 1);
        chk("brd T+7 wb_regwraddr", wb_regwraddr, 7);
        chk("brd T+7 wb_regwrdata", wb_regwrdata, 16'h00A5);
        chk("brd T+7 stall_out", stall_out, 0);
        tick();
        chk("brd T+8 wb_regwrite", wb_regwrite, 0);
        chk("brd T+8 stall_out", stall_out, 0);

        // Bus write with immediate ready.
        ex_valid = 1; ex_buswrite = 1; ex_regwrite = 1; ex_alu_out = 16'h0400; ex_src2_data = 16'h5A5A;
        bus_req_ready = 1;
        tick();
        idle_in();
        chk("bwr T+1 bus_req_valid", bus_req_valid, 1);
        chk("bwr T+1 bus_req_we", bus_req_we, 1);
        chk("bwr T+1 bus_req_addr", bus_req_addr, 16'h0400);
        chk("bwr T+1 bus_req_wdata", bus_req_wdata, 16'h5A5A);
        chk("bwr T+1 wb_regwrite", wb_regwrite, 0);
        tick();
        chk("bwr T+2 bus_req_valid", bus_req_valid, 0);
        chk("bwr T+2 stall_out", stall_out, 0);
        chk("bwr T+2 wb_regwrite", wb_regwrite, 0);
        bus_req_ready = 0;

        // Reset while waiting in BUS_REQ.
        ex_valid = 1; ex_bustoreg = 1; ex_regwrite = 1; ex_alu_out = 16'h0500; ex_regwraddr = 4'd8;
        tick();
        idle_in();
        chk("rsb T+1 bus_req_valid", bus_req_valid, 1);
        tick();
        rst = 1;
        chk("rsb T+2 stall_out", stall_out, 1);
        tick();
        rst = 0;
        chk("rsb T+3 bus_req_valid", bus_req_valid, 0);
        chk("rsb T+3 stall_out", stall_out, 0);
        chk("rsb T+3 wb_regwrite", wb_regwrite, 0);
        bus_rsp_valid = 1; bus_rsp_data = 16'h1234;
        tick();
        bus_rsp_valid = 0;
        chk("rsb T+4 wb_regwrite", wb_regwrite, 0);
        chk("rsb T+4 wb_regwrdata", wb_regwrdata, 0);
        chk("rsb T+4 stall_out", stall_out, 0);

        // Bus that never becomes ready.
        ex_valid = 1; ex_bustoreg = 1; ex_regwrite = 1; ex_alu_out = 16'h0600; ex_regwraddr = 4'd9;
        tick();
        idle_in();
`ifdef MEMWB_BUS_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("to T+%0d bus_req_valid", c), bus_req_valid, 1);
            chk($sformatf("to T+%0d bus_timeout_err", c), bus_timeout_err, 0);
            tick();
        end
        chk("to T+9 bus_req_valid", bus_req_valid, 0);
        chk("to T+9 stall_out", stall_out, 0);
        chk("to T+9 bus_timeout_err", bus_timeout_err, 1);
        chk("to T+9 wb_regwrite", wb_regwrite, 0);
        ex_valid = 1; ex_regwrite = 1; ex_alu_out = 16'h7777; ex_regwraddr = 4'd2;
        tick();
        idle_in();
        chk("to alu wb_regwrite", wb_regwrite, 1);
        chk("to alu wb_regwraddr", wb_regwraddr, 2);
        chk("to alu wb_regwrdata", wb_regwrdata, 16'h7777);
        chk("to alu bus_timeout_err", bus_timeout_err, 1);
        tick();
        chk("to sticky bus_timeout_err", bus_timeout_err, 1);
`else
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("wait T+%0d bus_req_valid", c), bus_req_valid, 1);
            chk($sformatf("wait T+%0d stall_out", c), stall_out, 1);
            chk($sformatf("wait T+%0d bus_timeout_err", c), bus_timeout_err, 0);
            tick();
        end
        bus_req_ready = 1;
        tick();
        bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_data = 16'h0BAD;
        chk("wait rsp stall_out", stall_out, 1);
        tick();
        bus_rsp_valid = 0;
        chk("wait wb_regwrite", wb_regwrite, 1);
        chk("wait wb_regwraddr", wb_regwraddr, 9);
        chk("wait wb_regwrdata", wb_regwrdata, 16'h0BAD);
        chk("wait bus_timeout_err", bus_timeout_err, 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
